// File: rtl/mips_pkg.sv
// Shared pipeline/memory-bus constants: arbiter state encodings and default widths.
package mips_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_DACC = 2'd1;
    localparam logic [1:0] ARB_IACC = 2'd2;

    localparam int TIMEOUT_DEF = 15;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 32;

    function automatic logic is_access(input logic [1:0] state);
        return (state == ARB_DACC) || (state == ARB_IACC);
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Per-access watchdog: counts cycles spent waiting for bus_ack; expired marks the
// final permitted cycle (count == TIMEOUT-1). Held in clear while no access is active.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one variable-latency memory bus between fetch and M-stage; data first.
// Stalls the whole pipeline until this cycle's accesses are served or timed out.
module mem_bus_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] PCF,
    output logic [DATA_W-1:0] InstrF,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [ADDR_W-1:0] AluOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallPipe,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    logic [1:0]        r_state;
    logic              r_d_done;
    logic              r_i_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic w_busy;
    logic w_d_pend;
    logic w_i_pend;
    logic w_expired;

    assign w_busy    = is_access(r_state);
    assign w_d_pend  = (MemWriteM | MemtoRegM) & ~r_d_done;
    assign w_i_pend  = if_req & ~r_i_done;
    assign StallPipe = w_d_pend | w_i_pend | (r_state != ARB_IDLE);

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (~w_busy),
        .en      (w_busy & ~bus_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_instr  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            // Done flags only set while stalled, so clearing on advance never collides.
            if (!StallPipe) begin
                r_d_done <= 1'b0;
                r_i_done <= 1'b0;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (w_d_pend) begin
                        r_state <= ARB_DACC;
                        r_we    <= MemWriteM;
                        r_addr  <= AluOutM;
                        r_wdata <= WriteDataM;
                    end else if (w_i_pend) begin
                        r_state <= ARB_IACC;
                        r_we    <= 1'b0;
                        r_addr  <= PCF;
                        r_wdata <= '0;
                    end
                end
                ARB_DACC: begin
                    if (bus_ack) begin
                        r_state  <= ARB_IDLE;
                        r_d_done <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= bus_rdata;
                        end
                    end else if (w_expired) begin
                        r_state  <= ARB_IDLE;
                        r_d_done <= 1'b1;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                    end
                end
                ARB_IACC: begin
                    if (bus_ack) begin
                        r_state  <= ARB_IDLE;
                        r_i_done <= 1'b1;
                        r_instr  <= bus_rdata;
                    end else if (w_expired) begin
                        r_state  <= ARB_IDLE;
                        r_i_done <= 1'b1;
                        r_instr  <= '0;
                        r_err    <= 1'b1;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus_req   = w_busy;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign InstrF    = r_instr;
    assign ReadDataM = r_rdata;
    assign bus_err   = r_err;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-port, variable-latency memory bus between instruction fetch (IF) and the memory stage (M) of the 5-stage pipeline.
- Sequences each access with a req/ack handshake and buffers the returned word.
- Asserts a global stall that freezes every pipeline register, including the E->M register, until all of this cycle's accesses are served.
- A timeout aborts a hung access so the pipeline cannot deadlock.

Parameters:
- DATA_W, 32, bus/data width.
- ADDR_W, 32, bus address width.
- TIMEOUT, 15, max cycles in an access state before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch wants an instruction this cycle.
- PCF  in  ADDR_W  fetch address.
- InstrF  out  DATA_W  buffered instruction word.
- MemWriteM  in  1  M-stage store.
- MemtoRegM  in  1  M-stage load.
- AluOutM  in  ADDR_W  M-stage address.
- WriteDataM  in  DATA_W  store data.
- ReadDataM  out  DATA_W  buffered load data.
- StallPipe  out  1  freeze all pipeline registers and the PC.
- bus_req  out  1  access request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  access address.
- bus_wdata  out  DATA_W  write data.
- bus_rdata  in  DATA_W  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion pulse.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, D_ACC, I_ACC.
  - bus_req = 1 exactly when state is D_ACC or I_ACC.
  - bus_we, bus_addr and bus_wdata are registered on entry to an access state and held stable while bus_req = 1.
- Pending flags:
  - d_pend = (MemWriteM | MemtoRegM) & ~d_done.
  - i_pend = if_req & ~i_done.
- StallPipe = d_pend | i_pend | (state != IDLE). It is combinational from registers and inputs; no extra stall cycle is added.
- IDLE transitions:
  - d_pend goes to D_ACC. Data has priority because the older instruction is served first.
  - Otherwise i_pend goes to I_ACC.
  - Otherwise stay in IDLE.
- Access state with bus_ack = 1:
  - Capture bus_rdata into ReadDataM (D_ACC) or InstrF (I_ACC). Writes leave ReadDataM unchanged.
  - Set d_done or i_done.
  - Return to IDLE at the same edge. The next access can issue from the following IDLE cycle.
- Minimum latency:
  - One access with ack in its first request cycle: StallPipe high for 2 cycles.
  - Data plus fetch in the same cycle: 4 cycles.
- Done-flag clearing:
  - d_done and i_done clear on any edge where StallPipe = 0, i.e. the pipeline advances.
  - They hold while stalled, so a held M-stage instruction is never re-issued.
  - If the pipeline advances and a new request arrives in the same cycle, clear has priority; the new request is handled from the next cycle.
- Timeout:
  - 8-bit counter clears on entry to an access state and increments each cycle without ack.
  - If count reaches TIMEOUT-1 with no ack: abort, go to IDLE, set the corresponding done flag, load the buffer with 0, and set bus_err.
  - bus_err clears only on rst.
  - ack and timeout in the same cycle: ack wins and bus_err is not set.
- bus_ack while in IDLE is ignored.
- Reset values (asynchronous, applied immediately, including mid-access):
  - state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0.
  - InstrF 0, ReadDataM 0, d_done 0, i_done 0, counter 0, bus_err 0.
  - StallPipe follows its equation with the cleared state.
  - A memory device seeing bus_req drop mid-access must abandon that access.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings ARB_IDLE=2'd0, ARB_DACC=2'd1, ARB_IACC=2'd2;
  - TIMEOUT_DEF=15;
  - DATA_W/ADDR_W defaults.
- One natural sub-module, arb_timeout_cnt:
  - inputs clr and en;
  - output expired;
  - parameter TIMEOUT.
- The FSM, done flags and buffers stay in the top module.

Test Plan:
1. Reset mid-access: rst pulsed while state = D_ACC -> bus_req drops to 0 in the same cycle without a clock edge; all outputs return to reset values; after release, a pending request re-issues.
2. Load only, ack in 1st request cycle: MemtoRegM=1, AluOutM=0x0000_0040, rdata 0xDEAD_BEEF -> bus_req=1, bus_we=0, addr 0x40 for 1 cycle; ReadDataM=0xDEAD_BEEF; StallPipe high for exactly 2 cycles; no second request while the instruction is held.
3. Store plus fetch in the same cycle: MemWriteM=1, addr 0x80, wdata 0x1234_5678, if_req=1, PCF=0x0000_0004, ack after 3 cycles each -> data access issued first with bus_we=1, then fetch; InstrF captured; StallPipe deasserts only after both accesses complete.
4. Timeout: if_req=1, bus_ack never asserted, TIMEOUT=15 -> request aborts after 15 cycles; InstrF=0; bus_err=1 and stays set; StallPipe releases.
5. ack coinciding with the last timeout cycle -> data captured, bus_err stays 0.
6. Back-to-back loads on consecutive pipeline advances -> done flags clear on the advance edge; the second load issues the cycle after; no duplicate request and no dropped request.
